// File: rtl/obstacle_game_monitor.sv
// rtl/obstacle_game_monitor.sv - collision/score/speed monitor and game FSM
//
// Purpose: checks the obstacle box against the player box through a 2-stage
// pipeline, scores passed obstacles in 4-digit BCD, raises obstacle speed
// every SPEED_STEP passes, runs the idle/run/hit/over game FSM and keeps a
// high score across games.
//
// Ports:
//   clock, reset       system clock, asynchronous active-low reset
//   start              1-cycle start/restart strobe (honoured in IDLE/OVER)
//   xSprite, ySprite   obstacle position
//   obstacleId         obstacle sprite id, 0 = no obstacle
//   passed             obstacle-passed flag, counted on its rising edge
//   xPlayer, yPlayer   player position
//   speed              obstacle speed fed back to the updater
//   score, highScore   4-digit BCD current and best score
//   running            high in RUN
//   collision          high in HIT
//   gameOver           high in OVER
module obstacle_game_monitor #(
  parameter int          OBS_W      = 32,
  parameter int          OBS_H      = 32,
  parameter int          PLY_W      = 32,
  parameter int          PLY_H      = 32,
  parameter logic [8:0]  SPEED_INIT = 9'd2,
  parameter logic [8:0]  SPEED_MAX  = 9'd12,
  parameter int          SPEED_STEP = 5,
  parameter logic [15:0] HIT_CYCLES = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  xSprite,
  input  logic [8:0]  ySprite,
  input  logic [3:0]  obstacleId,
  input  logic        passed,
  input  logic [7:0]  xPlayer,
  input  logic [8:0]  yPlayer,
  output logic [8:0]  speed,
  output logic [15:0] score,
  output logic [15:0] highScore,
  output logic        running,
  output logic        collision,
  output logic        gameOver
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT, S_OVER} state_t;

  localparam logic [9:0] OBS_W10 = 10'(OBS_W);
  localparam logic [9:0] OBS_H10 = 10'(OBS_H);
  localparam logic [9:0] PLY_W10 = 10'(PLY_W);
  localparam logic [9:0] PLY_H10 = 10'(PLY_H);
  localparam logic [7:0] STEP_LAST = 8'(SPEED_STEP - 1);

  state_t      state, state_nxt;
  logic [4:0]  s1;
  logic        hitQ;
  logic        passedQ;
  logic        passed_edge;
  logic [7:0]  step_cnt;
  logic [15:0] hit_cnt;
  logic [9:0]  xs10, xp10, ys10, yp10;
  logic [3:0]  cmp;

  // Zero-extended to 10 bits so position + size can never wrap.
  assign xs10 = {2'b00, xSprite};
  assign xp10 = {2'b00, xPlayer};
  assign ys10 = {1'b0, ySprite};
  assign yp10 = {1'b0, yPlayer};

  // Strict compares: boxes that only touch do not overlap.
  assign cmp[0] = xs10 < xp10 + PLY_W10;
  assign cmp[1] = xp10 < xs10 + OBS_W10;
  assign cmp[2] = ys10 < yp10 + PLY_H10;
  assign cmp[3] = yp10 < ys10 + OBS_H10;

  assign passed_edge = passed & ~passedQ;

  assign running   = (state == S_RUN);
  assign collision = (state == S_HIT);
  assign gameOver  = (state == S_OVER);

  // Saturating 4-digit BCD increment with decimal carry.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Collision pipeline. Held clear outside RUN so a new game always starts
  // with an empty pipeline and cannot be ended by a hit from the last one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1      <= 5'd0;
      hitQ    <= 1'b0;
      passedQ <= 1'b0;
    end else begin
      passedQ <= passed;
      if (state != S_RUN) begin
        s1   <= 5'd0;
        hitQ <= 1'b0;
      end else begin
        s1   <= {(obstacleId != 4'd0), cmp};
        hitQ <= &s1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (hitQ) state_nxt = S_HIT;
      S_HIT:   if (hit_cnt == HIT_CYCLES - 16'd1) state_nxt = S_OVER;
      S_OVER:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      score     <= 16'h0000;
      highScore <= 16'h0000;
      speed     <= SPEED_INIT;
      step_cnt  <= 8'd0;
      hit_cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            score    <= 16'h0000;
            speed    <= SPEED_INIT;
            step_cnt <= 8'd0;
          end
        end
        S_RUN: begin
          // A registered hit wins over a same-cycle pass.
          if (hitQ) begin
            hit_cnt <= 16'd0;
          end else if (passed_edge) begin
            score <= bcd_inc(score);
            if (step_cnt == STEP_LAST) begin
              step_cnt <= 8'd0;
              if (speed < SPEED_MAX) speed <= speed + 9'd1;
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        S_HIT: begin
          hit_cnt <= hit_cnt + 16'd1;
          // Valid BCD orders the same as plain binary (MSD in the top bits),
          // so a straight unsigned compare is a digit-wise compare.
          if (state_nxt == S_OVER && score > highScore) highScore <= score;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_game_monitor.sv
// tb/tb_obstacle_game_monitor.sv - self-checking bench for obstacle_game_monitor
module tb_obstacle_game_monitor;

  localparam int HIT = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  xSprite = 8'd200;
  logic [8:0]  ySprite = 9'd400;
  logic [3:0]  obstacleId = 4'd0;
  logic        passed = 1'b0;
  logic [7:0]  xPlayer = 8'd40;
  logic [8:0]  yPlayer = 9'd100;
  logic [8:0]  speed;
  logic [15:0] score;
  logic [15:0] highScore;
  logic        running;
  logic        collision;
  logic        gameOver;

  int n_cmp  = 0;
  int n_fail = 0;

  obstacle_game_monitor #(.HIT_CYCLES(16'(HIT))) dut (
    .clock(clock), .reset(reset), .start(start),
    .xSprite(xSprite), .ySprite(ySprite), .obstacleId(obstacleId),
    .passed(passed), .xPlayer(xPlayer), .yPlayer(yPlayer),
    .speed(speed), .score(score), .highScore(highScore),
    .running(running), .collision(collision), .gameOver(gameOver)
  );

  always #5 clock = ~clock;

  // Reference model: decimal score, pass count, game phase 0..3 =
  // idle/run/hit/over, and a short history of raw overlap and phase.
  int m_state = 0, m_score = 0, m_hs = 0, m_speed = 2, m_passes = 0, m_cnt = 0;
  bit m_prev_passed = 0, raw_h1 = 0, raw_h2 = 0, run_h1 = 0, run_h2 = 0;
  bit raw_now, edge_now, hq, in_run;

  function automatic int to_bcd(input int v);
    return (v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_score = 0; m_hs = 0; m_speed = 2; m_passes = 0; m_cnt = 0;
      m_prev_passed = 0; raw_h1 = 0; raw_h2 = 0; run_h1 = 0; run_h2 = 0;
    end else begin
      raw_now = (int'(xSprite) < int'(xPlayer) + 32) && (int'(xPlayer) < int'(xSprite) + 32) &&
                (int'(ySprite) < int'(yPlayer) + 32) && (int'(yPlayer) < int'(ySprite) + 32) &&
                (obstacleId != 0);
      edge_now = passed && !m_prev_passed;
      // A hit seen two cycles ago only counts if the game was running then
      // and in the cycle after it.
      hq = run_h1 && run_h2 && raw_h2;
      in_run = (m_state == 1);
      case (m_state)
        0, 3: if (start) begin
          m_state = 1; m_score = 0; m_speed = 2; m_passes = 0;
        end
        1: if (hq) begin
          m_state = 2; m_cnt = 0;
        end else if (edge_now) begin
          m_passes++;
          if (m_score < 9999) m_score++;
          if (m_passes % 5 == 0 && m_speed < 12) m_speed++;
        end
        2: begin
          m_cnt++;
          if (m_cnt == HIT) begin
            m_state = 3;
            if (m_score > m_hs) m_hs = m_score;
          end
        end
        default: ;
      endcase
      m_prev_passed = passed;
      raw_h2 = raw_h1; raw_h1 = raw_now;
      run_h2 = run_h1; run_h1 = in_run;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("speed", int'(speed), m_speed);
    chk("score", int'(score), to_bcd(m_score));
    chk("highScore", int'(highScore), to_bcd(m_hs));
    chk("running", int'(running), int'(m_state == 1));
    chk("collision", int'(collision), int'(m_state == 2));
    chk("gameOver", int'(gameOver), int'(m_state == 3));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse();
    passed = 1'b1; tick();
    passed = 1'b0; tick();
  endtask

  task automatic do_start();
    start = 1'b1; tick();
    start = 1'b0;
  endtask

  task automatic away();
    xSprite = 8'd200; ySprite = 9'd400; obstacleId = 4'd0;
  endtask

  task automatic hit_obs();
    xSprite = 8'd40; ySprite = 9'd120; obstacleId = 4'd6;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_speed", int'(speed), 2);
    chk("rst_score", int'(score), 0);
    chk("rst_hs", int'(highScore), 0);
    chk("rst_flags", int'({running, collision, gameOver}), 0);
    reset = 1'b1; tick();

    do_start();
    chk("g1_running", int'(running), 1);
    chk("g1_score0", int'(score), 16'h0000);
    repeat (3) pulse();
    chk("score3", int'(score), 16'h0003);
    chk("speed3", int'(speed), 2);
    repeat (2) pulse();
    chk("score5", int'(score), 16'h0005);
    chk("speed5", int'(speed), 3);

    xSprite = 8'd72; ySprite = 9'd100; obstacleId = 4'd6;
    repeat (6) tick();
    chk("touch_nohit", int'({running, collision}), 2);
    xSprite = 8'd40; ySprite = 9'd120; obstacleId = 4'd0;
    repeat (6) tick();
    chk("id0_nohit", int'({running, collision}), 2);
    away();

    repeat (4) pulse();
    chk("score9", int'(score), 16'h0009);
    pulse();
    chk("score10_carry", int'(score), 16'h0010);
    chk("speed10", int'(speed), 4);

    hit_obs();
    tick(); tick();
    chk("hit_lat2", int'(collision), 0);
    passed = 1'b1; tick();
    chk("hit_lat3", int'(collision), 1);
    chk("hit_beats_pass", int'(score), 16'h0010);
    passed = 1'b0;
    do_start();
    chk("start_in_hit", int'(collision), 1);
    repeat (HIT - 2) tick();
    chk("hit_hold", int'(collision), 1);
    tick();
    chk("over", int'(gameOver), 1);
    chk("hs_g1", int'(highScore), 16'h0010);
    away(); tick();

    do_start();
    chk("g2_running", int'(running), 1);
    chk("g2_score0", int'(score), 16'h0000);
    chk("g2_speed", int'(speed), 2);
    repeat (3) pulse();
    hit_obs();
    repeat (3 + HIT) tick();
    chk("g2_over", int'(gameOver), 1);
    chk("g2_hs_kept", int'(highScore), 16'h0010);
    away(); tick();

    do_start();
    repeat (10002) pulse();
    chk("score_sat", int'(score), 16'h9999);
    chk("speed_sat", int'(speed), 12);

    reset = 1'b0; #1;
    chk("arst_flags", int'({running, collision, gameOver}), 0);
    chk("arst_score", int'(score), 0);
    chk("arst_hs", int'(highScore), 0);
    chk("arst_speed", int'(speed), 2);
    tick();
    reset = 1'b1; tick();

    do_start();
    for (int i = 0; i < 4000; i++) begin
      passed = ($urandom_range(0, 2) == 0);
      start  = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 7) == 0) begin
        xSprite    = 8'($urandom_range(0, 120));
        ySprite    = 9'($urandom_range(50, 170));
        obstacleId = 4'($urandom_range(0, 3));
      end
      reset = ($urandom_range(0, 999) != 0);
      tick();
    end
    reset = 1'b1; start = 1'b0; passed = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
